// File: rtl/disk_decoder_32bit.sv
// disk_decoder_32bit: inverts the disk mapping with a CORDIC vectoring core (turn-fraction angle, saturated r^2).
// Define DISK_DECODER_RANGE_CHECK_EN to add the out_range_err output.
module disk_decoder_32bit #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] vdc0_out,
  output logic [31:0] vdc1_out
`ifdef DISK_DECODER_RANGE_CHECK_EN
  ,
  output logic        out_range_err
`endif
);
  typedef enum logic [1:0] {IDLE, PREP, ROTATE, DONE} state_t;
  localparam logic [4:0] ITER_L = 5'(ITER);

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        vdc0_q, vdc0_d, vdc1_q, vdc1_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic [31:0]        z_q, z_d, r2_q, r2_d;
  logic               zero_q, zero_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [63:0] x_ext, y_ext, x_sq, y_sq;
  logic [63:0]        r2_full;
  logic signed [33:0] x_sh, y_sh;
`ifdef DISK_DECODER_RANGE_CHECK_EN
  logic               ovf_q, ovf_d, range_err_q, range_err_d;
`endif

  // Angle step table in turn units: round(atan(2^-i) / 2pi * 2^32).
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  atan_lut = 32'h2000_0000;  5'd1:  atan_lut = 32'h12E4_051E;
      5'd2:  atan_lut = 32'h09FB_385B;  5'd3:  atan_lut = 32'h0511_11D4;
      5'd4:  atan_lut = 32'h028B_0D43;  5'd5:  atan_lut = 32'h0145_D7E1;
      5'd6:  atan_lut = 32'h00A2_F61E;  5'd7:  atan_lut = 32'h0051_7C55;
      5'd8:  atan_lut = 32'h0028_BE53;  5'd9:  atan_lut = 32'h0014_5F2F;
      5'd10: atan_lut = 32'h000A_2F98;  5'd11: atan_lut = 32'h0005_17CC;
      5'd12: atan_lut = 32'h0002_8BE6;  5'd13: atan_lut = 32'h0001_45F3;
      5'd14: atan_lut = 32'h0000_A2FA;  5'd15: atan_lut = 32'h0000_517D;
      5'd16: atan_lut = 32'h0000_28BE;  5'd17: atan_lut = 32'h0000_145F;
      5'd18: atan_lut = 32'h0000_0A30;  5'd19: atan_lut = 32'h0000_0518;
      5'd20: atan_lut = 32'h0000_028C;  5'd21: atan_lut = 32'h0000_0146;
      5'd22: atan_lut = 32'h0000_00A3;  5'd23: atan_lut = 32'h0000_0051;
      5'd24: atan_lut = 32'h0000_0029;  5'd25: atan_lut = 32'h0000_0014;
      5'd26: atan_lut = 32'h0000_000A;  5'd27: atan_lut = 32'h0000_0005;
      5'd28: atan_lut = 32'h0000_0003;  5'd29: atan_lut = 32'h0000_0001;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    vdc0_d      = vdc0_q;
    vdc1_d      = vdc1_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    r2_d        = r2_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
`ifdef DISK_DECODER_RANGE_CHECK_EN
    ovf_d       = ovf_q;
    range_err_d = range_err_q;
`endif
    x_ext   = $signed({{30{x_q[33]}}, x_q});
    y_ext   = $signed({{30{y_q[33]}}, y_q});
    x_sq    = x_ext * x_ext;
    y_sq    = y_ext * y_ext;
    r2_full = ($unsigned(x_sq) + $unsigned(y_sq)) >> 28;
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d    = PREP;
          in_ready_d = 1'b0;
          x_d        = {{2{in_x[31]}}, in_x};
          y_d        = {{2{in_y[31]}}, in_y};
        end
      end
      PREP: begin
        state_d = ROTATE;
        cnt_d   = 5'd0;
        zero_d  = (x_q == 34'sd0) && (y_q == 34'sd0);
        r2_d    = (|r2_full[63:32]) ? 32'hFFFF_FFFF : r2_full[31:0];
`ifdef DISK_DECODER_RANGE_CHECK_EN
        ovf_d   = |r2_full[63:32];
`endif
        // Fold the left half-plane onto the right so vectoring converges.
        if (x_q[33]) begin
          x_d = -x_q;
          y_d = -y_q;
          z_d = 32'h8000_0000;
        end else begin
          z_d = 32'h0000_0000;
        end
      end
      ROTATE: begin
        // The cycle after the last micro-rotation registers the results.
        if (cnt_q == ITER_L) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          vdc0_d      = zero_q ? 32'h0000_0000 : z_q;
          vdc1_d      = r2_q;
`ifdef DISK_DECODER_RANGE_CHECK_EN
          range_err_d = ovf_q;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (!y_q[33]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_lut(cnt_q);
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_lut(cnt_q);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      vdc0_q      <= '0;
      vdc1_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      r2_q        <= '0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
`ifdef DISK_DECODER_RANGE_CHECK_EN
      ovf_q       <= 1'b0;
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      vdc0_q      <= vdc0_d;
      vdc1_q      <= vdc1_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      r2_q        <= r2_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
`ifdef DISK_DECODER_RANGE_CHECK_EN
      ovf_q       <= ovf_d;
      range_err_q <= range_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign vdc0_out  = vdc0_q;
  assign vdc1_out  = vdc1_q;
`ifdef DISK_DECODER_RANGE_CHECK_EN
  assign out_range_err = range_err_q;
`endif

endmodule

// File: tb/tb_disk_decoder_32bit.sv
// Directed bench for disk_decoder_32bit (ITER=16): vector table plus back-pressure and mid-operation reset sequences.
module tb_disk_decoder_32bit;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vdc0_out;
  logic [31:0] vdc1_out;
`ifdef DISK_DECODER_RANGE_CHECK_EN
  logic        out_range_err;
`endif

  int checks;
  int errors;

  localparam logic [31:0] TOL = 32'h0002_0000;

  disk_decoder_32bit #(.ITER(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vdc0_out  (vdc0_out),
    .vdc1_out  (vdc1_out)
`ifdef DISK_DECODER_RANGE_CHECK_EN
    ,
    .out_range_err (out_range_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ang;
    logic [31:0] tol;
    logic [31:0] r2;
    logic        rng;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_ang(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input logic [31:0] tol);
    logic [31:0] d;
    d = got - exp;
    if (d[31]) d = -d;
    checks++;
    if ((^got === 1'bx) || (d > tol)) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h +/- 0x%08h", name, got, exp, tol);
    end
  endtask

  // Handshake one point; returns at the negedge following the transfer edge.
  task automatic start(input logic [31:0] x, input logic [31:0] y, output bit ok);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_x = $urandom;
      in_y = $urandom;
    end
  endtask

  // Full transaction up to out_valid; lat counts edges after the transfer edge.
  task automatic transact(input logic [31:0] x, input logic [31:0] y, output int lat);
    bit ok;
    start(x, y, ok);
    lat = -1;
    if (ok) begin
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " out_valid after transfer"}, {31'd0, out_valid}, 32'd0);
    chk({name, " in_ready after transfer"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    bit ok;
    logic [31:0] first0;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;

    vecs[0]  = '{32'h2000_0000, 32'h0000_0000, 32'h0000_0000, TOL, 32'h4000_0000, 1'b0};
    vecs[1]  = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, TOL, 32'h4000_0000, 1'b0};
    vecs[2]  = '{32'hE000_0000, 32'h0000_0000, 32'h8000_0000, TOL, 32'h4000_0000, 1'b0};
    vecs[3]  = '{32'h0000_0000, 32'hE000_0000, 32'hC000_0000, TOL, 32'h4000_0000, 1'b0};
    vecs[4]  = '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, TOL, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h1000_0000, 32'h1000_0000, 32'h2000_0000, TOL, 32'h2000_0000, 1'b0};
    vecs[7]  = '{32'hF000_0000, 32'h1000_0000, 32'h6000_0000, TOL, 32'h2000_0000, 1'b0};
    vecs[8]  = '{32'h2000_0000, 32'hE000_0000, 32'hE000_0000, TOL, 32'h8000_0000, 1'b0};
    vecs[9]  = '{32'h3000_0000, 32'h3000_0000, 32'h2000_0000, TOL, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0000, TOL, 32'hFFFF_FFF8, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, TOL, 32'hFFFF_FFFF, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset vdc0", vdc0_out, 32'd0);
    chk("reset vdc1", vdc1_out, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready before first edge after release", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready after release", {31'd0, in_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      transact(vecs[i].x, vecs[i].y, lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd18);
      chk_ang($sformatf("v%0d vdc0", i), vdc0_out, vecs[i].ang, vecs[i].tol);
      chk($sformatf("v%0d vdc1", i), vdc1_out, vecs[i].r2);
`ifdef DISK_DECODER_RANGE_CHECK_EN
      chk($sformatf("v%0d range_err", i), {31'd0, out_range_err}, {31'd0, vecs[i].rng});
`endif
      $display("txn %0d: x=0x%08h y=0x%08h vdc0=0x%08h vdc1=0x%08h latency=%0d",
               i, vecs[i].x, vecs[i].y, vdc0_out, vdc1_out, lat);
      release_out($sformatf("v%0d", i));
    end

    // Back-pressure: hold out_ready low for 10 cycles
    transact(32'h0000_0000, 32'h2000_0000, lat);
    chk("bp latency", 32'(lat), 32'd18);
    first0 = vdc0_out;
    chk_ang("bp vdc0", vdc0_out, 32'h4000_0000, TOL);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp c%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp c%0d vdc0 stable", c), vdc0_out, first0);
      chk($sformatf("bp c%0d vdc1", c), vdc1_out, 32'h4000_0000);
    end
    $display("txn bp: vdc0=0x%08h vdc1=0x%08h held 10 cycles", vdc0_out, vdc1_out);
    release_out("bp");

    // Reset in the middle of ROTATE
    start(32'h2000_0000, 32'h2000_0000, ok);
    chk("mid start accepted", {31'd0, ok}, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst vdc1", vdc1_out, 32'd0);
    chk("mid rst vdc0", vdc0_out, 32'd0);
    repeat (2) @(negedge clk);
    chk("mid rst held in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid release in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("mid no result emitted", 32'(seen), 32'd0);
    $display("txn mid-reset: operation discarded");
    transact(32'h1000_0000, 32'h1000_0000, lat);
    chk("post-rst latency", 32'(lat), 32'd18);
    chk_ang("post-rst vdc0", vdc0_out, 32'h2000_0000, TOL);
    chk("post-rst vdc1", vdc1_out, 32'h2000_0000);
    $display("txn post-reset: vdc0=0x%08h vdc1=0x%08h latency=%0d", vdc0_out, vdc1_out, lat);
    release_out("post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
